alu_exec_unit: RTL and testbench

- Execute stage directly downstream of the register unit. Consumes the SR1_out/SR2_out register-file read ports plus IR immediate bits, and computes a result.
- Returns the result to the datapath bus through a GateALU tri-state-free mux output. Optionally updates the NZP condition codes.
- Single-cycle ops (ADD/AND/NOT/PASSA/SUB) complete in one execute cycle. MUL is a multi-cycle shift-add sequence with a start/busy/done handshake.

---
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_exec_unit.sv | 128 ++++++++++++
 tb/tb_alu_exec_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operand, control and result bundle between the register unit, the ALU execute stage and the bus.
// The master drives operands and requests. The slave returns status, the result and the condition codes.
interface alu_exec_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       ALUK;
    logic             SR2MUX;
    logic [4:0]       ir_4_0;
    logic [WIDTH-1:0] SR1_out;
    logic [WIDTH-1:0] SR2_out;
    logic             LD_CC;
    logic             GateALU;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] bus_drive;
    logic             N;
    logic             Z;
    logic             P;

    modport master (
        output start, ALUK, SR2MUX, ir_4_0, SR1_out, SR2_out, LD_CC, GateALU,
        input  busy, done, alu_out, bus_drive, N, Z, P
    );

    modport slave (
        input  start, ALUK, SR2MUX, ir_4_0, SR1_out, SR2_out, LD_CC, GateALU,
        output busy, done, alu_out, bus_drive, N, Z, P
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: ADD/AND/NOT/PASSA/SUB plus a shift-add MUL, with optional NZP condition-code update.
// Latency: 1 cycle after the start edge for single-cycle ops, WIDTH cycles for MUL.
// Backpressure: start is accepted only while idle (busy=0); a start during an op is dropped, not queued.
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    alu_exec_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [2:0]       op_q;
    logic             ld_cc_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] exec_res;
    logic [WIDTH-1:0] mul_acc_nxt;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
        if (r[WIDTH-1])
            nzp_of = 3'b100;
        else if (r == '0)
            nzp_of = 3'b010;
        else
            nzp_of = 3'b001;
    endfunction

    always_comb begin
        b_sel = bus.SR2MUX ? {{(WIDTH-5){bus.ir_4_0[4]}}, bus.ir_4_0} : bus.SR2_out;
    end

    // Reserved opcodes 110/111 fall through to PASSA.
    always_comb begin
        exec_res = a_q;
        case (op_q)
            OP_ADD:   exec_res = a_q + b_q;
            OP_AND:   exec_res = a_q & b_q;
            OP_NOT:   exec_res = ~a_q;
            OP_PASSA: exec_res = a_q;
            OP_SUB:   exec_res = a_q + ~b_q + WIDTH'(1);
            default:  exec_res = a_q;
        endcase
    end

    // During MUL, a_q holds the multiplicand shifted left and b_q the multiplier shifted right.
    always_comb begin
        mul_acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            ld_cc_q     <= 1'b0;
            cnt_q       <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.alu_out <= '0;
            bus.N       <= 1'b0;
            bus.Z       <= 1'b1;
            bus.P       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.SR1_out;
                        b_q      <= b_sel;
                        op_q     <= bus.ALUK;
                        ld_cc_q  <= bus.LD_CC;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state    <= (bus.ALUK == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    bus.alu_out <= exec_res;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                    if (ld_cc_q)
                        {bus.N, bus.Z, bus.P} <= nzp_of(exec_res);
                end
                MUL: begin
                    acc_q <= mul_acc_nxt;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bus.alu_out <= mul_acc_nxt;
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                        if (ld_cc_q)
                            {bus.N, bus.Z, bus.P} <= nzp_of(mul_acc_nxt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_drive = bus.GateALU ? bus.alu_out : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases followed by randomized ops against an arithmetic model.
module tb_alu_exec_unit;
    localparam int WIDTH = 16;

    logic Clk;
    logic Reset;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] res;
        logic [2:0]  nzp;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] mon_out;
    logic [2:0]  mon_nzp;
    logic [2:0]  mdl_nzp;
    bit          gate_force;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    ref_alu = a + b;
            3'd1:    ref_alu = a & b;
            3'd2:    ref_alu = ~a;
            3'd4:    ref_alu = 16'(32'(a) * 32'(b));
            3'd5:    ref_alu = a - b;
            default: ref_alu = a;
        endcase
    endfunction

    function automatic logic [2:0] ref_nzp(input logic [15:0] r);
        if ($signed(r) < 0)
            ref_nzp = 3'b100;
        else if (r == 16'd0)
            ref_nzp = 3'b010;
        else
            ref_nzp = 3'b001;
    endfunction

    // Bus enable toggles randomly unless a directed case pins it high.
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            bus.GateALU = gate_force ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge Clk) begin
        if (Reset === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done at cycle %0d: got done=1, expected no completion", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("result", 32'(bus.alu_out), 32'(mon_e.res));
                check("busy_at_done", 32'(bus.busy), 32'(0));
                mon_out = mon_e.res;
                mon_nzp = mon_e.nzp;
            end
        end
        check("alu_out_hold", 32'(bus.alu_out), 32'(mon_out));
        check("nzp", 32'({bus.N, bus.Z, bus.P}), 32'(mon_nzp));
        check("bus_drive", 32'(bus.bus_drive), 32'(bus.GateALU ? mon_out : 16'h0000));
    end

    task automatic scramble();
        bus.SR1_out = 16'($urandom);
        bus.SR2_out = 16'($urandom);
        bus.ir_4_0  = 5'($urandom);
        bus.ALUK    = 3'($urandom);
        bus.SR2MUX  = 1'($urandom);
        bus.LD_CC   = 1'($urandom);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b2,
                         input logic mux, input logic [4:0] imm, input logic ld);
        logic [15:0] b;
        logic [15:0] r;
        exp_t        e;
        int          guard;
        b = mux ? {{11{imm[4]}}, imm} : b2;
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
        end while (bus.busy !== 1'b0 && guard < 100);
        if (guard >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout at cycle %0d: got busy=%b, expected 0", cyc, bus.busy);
        end
        r = ref_alu(op, a, b);
        if (ld)
            mdl_nzp = ref_nzp(r);
        e.res = r;
        e.nzp = mdl_nzp;
        e.cyc = cyc + 1 + ((op == 3'b100) ? 16 : 1);
        exp_q.push_back(e);
        bus.ALUK    = op;
        bus.SR1_out = a;
        bus.SR2_out = b2;
        bus.SR2MUX  = mux;
        bus.ir_4_0  = imm;
        bus.LD_CC   = ld;
        bus.start   = 1'b1;
        @(posedge Clk);
        #1;
        bus.start = 1'b0;
        scramble();
        @(negedge Clk);
        check("busy_after_start", 32'(bus.busy), 32'(1));
    endtask

    initial begin
        int guard;
        Reset       = 1'b0;
        bus.start   = 1'b0;
        bus.ALUK    = 3'd0;
        bus.SR2MUX  = 1'b0;
        bus.ir_4_0  = 5'd0;
        bus.SR1_out = 16'd0;
        bus.SR2_out = 16'd0;
        bus.LD_CC   = 1'b0;
        bus.GateALU = 1'b1;
        gate_force  = 1'b1;
        mon_out     = 16'd0;
        mon_nzp     = 3'b010;
        mdl_nzp     = 3'b010;

        repeat (3) @(negedge Clk);
        check("rst_alu_out", 32'(bus.alu_out), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_nzp", 32'({bus.N, bus.Z, bus.P}), 32'(3'b010));
        check("rst_bus_drive", 32'(bus.bus_drive), 32'(0));
        @(posedge Clk);
        #2 Reset = 1'b1;

        issue(3'b000, 16'h0005, 16'h0000, 1'b1, 5'b11101, 1'b1);
        issue(3'b010, 16'h00FF, 16'h5A5A, 1'b0, 5'd0, 1'b1);
        issue(3'b001, 16'hF0F0, 16'h0FF0, 1'b0, 5'd0, 1'b0);

        // MUL with operand change at k+3 and a stray start sampled at k+5.
        issue(3'b100, 16'h0003, 16'hFFFE, 1'b0, 5'd0, 1'b1);
        @(posedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        #1 bus.SR1_out = 16'h1234;
        @(posedge Clk);
        #1;
        bus.ALUK  = 3'b000;
        bus.start = 1'b1;
        @(posedge Clk);
        #1 bus.start = 1'b0;
        @(negedge Clk);
        check("busy_mid_mul", 32'(bus.busy), 32'(1));

        issue(3'b101, 16'h8000, 16'h8000, 1'b0, 5'd0, 1'b1);
        issue(3'b111, 16'h1234, 16'hBEEF, 1'b0, 5'd0, 1'b1);

        // MUL aborted by reset after edge k+8.
        issue(3'b100, 16'h0007, 16'h0009, 1'b0, 5'd0, 1'b1);
        repeat (8) @(posedge Clk);
        #2;
        exp_q.delete();
        mon_out = 16'd0;
        mon_nzp = 3'b010;
        mdl_nzp = 3'b010;
        Reset   = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        check("abort_alu_out", 32'(bus.alu_out), 32'(0));
        check("abort_nzp", 32'({bus.N, bus.Z, bus.P}), 32'(3'b010));
        @(posedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        repeat (20) @(negedge Clk);
        issue(3'b100, 16'h0007, 16'h0009, 1'b0, 5'd0, 1'b1);

        gate_force = 1'b0;
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = a;
                1:       a = 16'h0000;
                2:       b = 16'hFFFF;
                default: ;
            endcase
            issue(3'($urandom_range(0, 7)), a, b, 1'($urandom), 5'($urandom), 1'($urandom));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
